// File: rtl/aes_pkg.sv
// Constants and types shared by the AES wrapper and its result streamer.
package aes_pkg;

    localparam int unsigned AES_OUTPUT_BASE_ADDR = 257;
    localparam logic [31:0] AES_TERMINATOR       = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_CHECK,
        ST_SEND,
        ST_DONE
    } streamer_state_t;

endpackage

// File: rtl/aes_result_streamer.sv
// Reads result dwords from the AES BRAM output region after completion and
// serializes them MSB-first onto a valid/ready byte stream.
module aes_result_streamer
    import aes_pkg::*;
#(
    parameter int unsigned OUT_BASE_ADDR = AES_OUTPUT_BASE_ADDR,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned MAX_WORDS     = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic [9:0]  mem_addr_out,
    input  logic [31:0] mem_data_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        overflow_out,
    output logic [9:0]  word_count_out
);

    localparam logic [9:0] BASE_ADDR = 10'(OUT_BASE_ADDR);
    localparam logic [9:0] WORD_CAP  = 10'(MAX_WORDS);
    localparam logic [7:0] LAT_INIT  = 8'(READ_LATENCY - 1);

    streamer_state_t state;
    logic            start_q;
    logic [7:0]      lat_cnt;
    logic [31:0]     shift_reg;
    logic [1:0]      byte_idx;
    logic            start_edge;

    assign start_edge = start_in & ~start_q;

    // word_count_out doubles as the word pointer: both advance together on the 4th byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            start_q        <= 1'b0;
            mem_addr_out   <= BASE_ADDR;
            byte_out       <= '0;
            byte_valid_out <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            overflow_out   <= 1'b0;
            word_count_out <= '0;
            lat_cnt        <= '0;
            shift_reg      <= '0;
            byte_idx       <= '0;
        end else begin
            start_q  <= start_in;
            done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        word_count_out <= '0;
                        overflow_out   <= 1'b0;
                        busy_out       <= 1'b1;
                        state          <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    mem_addr_out <= BASE_ADDR + word_count_out;
                    lat_cnt      <= LAT_INIT;
                    state        <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        shift_reg <= mem_data_in;
                        state     <= ST_CHECK;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (shift_reg == AES_TERMINATOR) begin
                        done_out <= 1'b1;
                        state    <= ST_DONE;
                    end else if (word_count_out == WORD_CAP) begin
                        overflow_out <= 1'b1;
                        done_out     <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        byte_idx       <= '0;
                        byte_out       <= shift_reg[31:24];
                        byte_valid_out <= 1'b1;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // byte_valid_out is always high here, so ready alone marks a transfer.
                    if (byte_ready_in) begin
                        if (byte_idx == 2'd3) begin
                            byte_valid_out <= 1'b0;
                            word_count_out <= word_count_out + 10'd1;
                            state          <= ST_RD_ISSUE;
                        end else begin
                            shift_reg <= {shift_reg[23:0], 8'h00};
                            byte_out  <= shift_reg[23:16];
                            byte_idx  <= byte_idx + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_result_streamer.sv
// Randomized self-checking bench for aes_result_streamer against a
// queue-based reference model of the output buffer walk.
module tb_aes_result_streamer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in;
    logic        start_in, start_cap;
    logic        byte_ready_in;
    logic [31:0] mem [0:1023];

    logic [9:0]  a_addr, b_addr, a_cnt, b_cnt;
    logic [31:0] a_data, b_data;
    logic [7:0]  a_byte, b_byte;
    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done, a_ovf, b_ovf;

    // One-register BRAM: data for an address is sampleable two edges after it changes.
    always @(posedge clk_in) begin
        a_data <= mem[a_addr];
        b_data <= mem[b_addr];
    end

    aes_result_streamer #(.OUT_BASE_ADDR(257), .READ_LATENCY(2), .MAX_WORDS(255)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .mem_addr_out(a_addr), .mem_data_in(a_data),
        .byte_out(a_byte), .byte_valid_out(a_valid), .byte_ready_in(byte_ready_in),
        .busy_out(a_busy), .done_out(a_done), .overflow_out(a_ovf), .word_count_out(a_cnt)
    );

    aes_result_streamer #(.OUT_BASE_ADDR(257), .READ_LATENCY(2), .MAX_WORDS(2)) dut_cap (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_cap),
        .mem_addr_out(b_addr), .mem_data_in(b_data),
        .byte_out(b_byte), .byte_valid_out(b_valid), .byte_ready_in(byte_ready_in),
        .busy_out(b_busy), .done_out(b_done), .overflow_out(b_ovf), .word_count_out(b_cnt)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Selected-instance view used by the monitor and the run task.
    logic       sel_cap;
    logic [7:0] s_byte;
    logic [9:0] s_cnt, s_addr;
    logic       s_valid, s_busy, s_done, s_ovf;
    always_comb begin
        s_byte  = sel_cap ? b_byte  : a_byte;
        s_cnt   = sel_cap ? b_cnt   : a_cnt;
        s_addr  = sel_cap ? b_addr  : a_addr;
        s_valid = sel_cap ? b_valid : a_valid;
        s_busy  = sel_cap ? b_busy  : a_busy;
        s_done  = sel_cap ? b_done  : a_done;
        s_ovf   = sel_cap ? b_ovf   : a_ovf;
    end

    logic [7:0]  obs_q[$];
    logic [7:0]  exp_q[$];
    int unsigned done_cnt, valid_cyc, busy_cyc;
    logic        ovf_at_start;
    bit          pv, pr, pbusy;
    logic [7:0]  pb;

    always @(negedge clk_in) begin
        if (rst_in) begin
            pv    = 1'b0;
            pbusy = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid_held", 32'(s_valid), 32'd1);
                chk("stall_byte_held", 32'(s_byte), 32'(pb));
            end
            if (s_valid && byte_ready_in) obs_q.push_back(s_byte);
            if (s_valid) valid_cyc++;
            if (s_done)  done_cnt++;
            if (s_busy)  busy_cyc++;
            if (s_busy && !pbusy) ovf_at_start = s_ovf;
            pv    = s_valid;
            pr    = byte_ready_in;
            pb    = s_byte;
            pbusy = s_busy;
        end
    end

    // Ready driver: 0 = always ready, 1 = random with one 3-cycle stall mid-dword, 2 = never ready.
    int unsigned rdy_mode;
    bit          stretched;
    int unsigned stretch_left;
    always @(posedge clk_in) begin
        #1;
        case (rdy_mode)
            0: byte_ready_in = 1'b1;
            1: begin
                if (!stretched && obs_q.size() == 2) begin
                    stretched    = 1'b1;
                    stretch_left = 3;
                end
                if (stretch_left > 0) begin
                    byte_ready_in = 1'b0;
                    stretch_left--;
                end else begin
                    byte_ready_in = 1'($urandom_range(0, 1));
                end
            end
            default: byte_ready_in = 1'b0;
        endcase
    end

    // Reference: walk the output region word by word until terminator or cap.
    function automatic void build_expected(input int unsigned cap, output int unsigned nwords, output bit ovf);
        logic [31:0] w;
        int unsigned idx;
        exp_q.delete();
        nwords = 0;
        ovf    = 1'b0;
        idx    = 0;
        while (1) begin
            w = mem[257 + idx];
            if (w == 32'hDEADBEEF) break;
            if (idx == cap) begin
                ovf = 1'b1;
                break;
            end
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            nwords++;
            idx++;
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hDEADBEEF) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic load_normal();
        mem[257] = 32'h3925841D;
        mem[258] = 32'h02DC09FB;
        mem[259] = 32'hDC118597;
        mem[260] = 32'h196A0B32;
        mem[261] = 32'hDEADBEEF;
    endtask

    task automatic clear_monitor();
        obs_q.delete();
        done_cnt     = 0;
        valid_cyc    = 0;
        busy_cyc     = 0;
        ovf_at_start = 1'bx;
        stretched    = 1'b0;
        stretch_left = 0;
    endtask

    task automatic do_run(input bit cap, input string tag, input bit poke);
        int unsigned nw, k, stage, n;
        bit          ov, seen;
        build_expected(cap ? 2 : 255, nw, ov);
        sel_cap = cap;
        start_in  = 1'b0;
        start_cap = 1'b0;
        @(posedge clk_in);
        #1;
        clear_monitor();
        if (cap) start_cap = 1'b1;
        else     start_in  = 1'b1;
        k = 0; stage = 0; seen = 1'b0;
        while (!seen && k < 4000) begin
            @(negedge clk_in);
            k++;
            if (s_done) seen = 1'b1;
            if (poke) begin
                if (stage == 0 && obs_q.size() >= 5) begin
                    start_in = 1'b0;
                    stage = 1;
                end else if (stage == 1) begin
                    start_in = 1'b1;
                    stage = 2;
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        // Negedge k follows posedge k-1 after the one that registered start.
        if (seen && rdy_mode == 0) chk({tag, "_latency"}, k - 2, nw * 8 + 4);
        chk({tag, "_word_count"}, 32'(s_cnt), nw);
        chk({tag, "_overflow"}, 32'(s_ovf), 32'(ov));
        repeat (3) @(negedge clk_in);
        @(posedge clk_in);
        chk({tag, "_busy_after"}, 32'(s_busy), 32'd0);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_ovf_cleared_at_start"}, 32'(ovf_at_start), 32'd0);
        chk({tag, "_byte_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"}, 32'(a_addr), 32'd257);
        chk({tag, "_byte"}, 32'(a_byte), 32'd0);
        chk({tag, "_valid"}, 32'(a_valid), 32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_done"}, 32'(a_done), 32'd0);
        chk({tag, "_ovf"}, 32'(a_ovf), 32'd0);
        chk({tag, "_cnt"}, 32'(a_cnt), 32'd0);
    endtask

    initial begin
        int unsigned nwr, k;
        rst_in    = 1'b1;
        start_in  = 1'b0;
        start_cap = 1'b0;
        rdy_mode  = 0;
        sel_cap   = 1'b0;
        byte_ready_in = 1'b1;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;
        clear_monitor();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_state("reset");
        chk("reset_cap_addr", 32'(b_addr), 32'd257);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        load_normal();
        do_run(1'b0, "normal", 1'b0);

        // start_in still high: a held level must not retrigger.
        clear_monitor();
        repeat (100) @(negedge clk_in);
        @(posedge clk_in);
        chk("held_start_busy", busy_cyc, 32'd0);
        chk("held_start_bytes", obs_q.size(), 32'd0);

        do_run(1'b0, "restart_busy", 1'b1);
        clear_monitor();
        repeat (20) @(negedge clk_in);
        @(posedge clk_in);
        chk("restart_busy_no_rerun", busy_cyc, 32'd0);

        mem[257] = 32'hDEADBEEF;
        do_run(1'b0, "empty", 1'b0);
        chk("empty_valid_cycles", valid_cyc, 32'd0);

        load_normal();
        rdy_mode = 1;
        do_run(1'b0, "backpressure", 1'b0);
        rdy_mode = 0;

        for (int unsigned i = 257; i <= 262; i++) mem[i] = rand_word();
        do_run(1'b1, "cap", 1'b0);
        clear_monitor();
        repeat (100) @(negedge clk_in);
        @(posedge clk_in);
        chk("cap_held_ovf", 32'(b_ovf), 32'd1);
        chk("cap_held_busy", busy_cyc, 32'd0);
        mem[259] = 32'hDEADBEEF;
        do_run(1'b1, "cap_rerun", 1'b0);

        for (int unsigned r = 0; r < 4; r++) begin
            nwr = $urandom_range(0, 6);
            for (int unsigned i = 0; i < nwr; i++) mem[257 + i] = rand_word();
            mem[257 + nwr] = 32'hDEADBEEF;
            rdy_mode = (r % 2 == 0) ? 1 : 0;
            do_run(1'b0, $sformatf("rand%0d", r), 1'b0);
        end
        rdy_mode = 0;

        // Reset after the 6th byte transfers, then replay from the first byte.
        load_normal();
        sel_cap = 1'b0;
        start_in = 1'b0;
        @(posedge clk_in);
        #1;
        clear_monitor();
        start_in = 1'b1;
        k = 0;
        while (obs_q.size() < 6 && k < 4000) begin
            @(negedge clk_in);
            k++;
        end
        chk("midreset_reached_6", obs_q.size(), 32'd6);
        rdy_mode = 2;
        @(posedge clk_in);
        #1;
        rst_in   = 1'b1;
        start_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("midreset_valid", 32'(a_valid), 32'd0);
        chk("midreset_busy", 32'(a_busy), 32'd0);
        chk("midreset_addr", 32'(a_addr), 32'd257);
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        rdy_mode = 0;
        do_run(1'b0, "replay", 1'b0);
        chk("replay_first_byte", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF_FFFF, 32'h39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_result_streamer.md
Name: aes_result_streamer

Overview:
- Downstream consumer of the AES wrapper.
- After the wrapper raises its completion flag, this block reads ciphertext/plaintext dwords from the output buffer region of the shared AES BRAM, starting at word address 257. It stops at the 32'hDEADBEEF terminator.
- Each dword is serialized MSB-first into a valid/ready byte stream that feeds the UART TX path.
- It owns a read-only BRAM port, so it never writes memory.

Parameters:
- OUT_BASE_ADDR, 257: word address of the first output dword.
- READ_LATENCY, 2: BRAM cycles from address presented to data valid on mem_data_in. Must be ≥1.
- MAX_WORDS, 255: hard cap on dwords streamed per run; prevents a runaway when the terminator is missing.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  connected to the AES completion flag (a level); a rising edge starts a run
- mem_addr_out  output  10  BRAM word address
- mem_data_in  input  32  BRAM read data
- byte_out  output  8  stream data
- byte_valid_out  output  1  stream valid
- byte_ready_in  input  1  stream ready from the consumer
- busy_out  output  1  high from accepted start until the DONE state exits
- done_out  output  1  one-cycle pulse at end of run
- overflow_out  output  1  level; set when the run ended on MAX_WORDS instead of the terminator; cleared on next start
- word_count_out  output  10  dwords streamed in the current/last run

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high (rst_in).
- Reset state:
  - state = IDLE.
  - mem_addr_out = OUT_BASE_ADDR.
  - byte_out = 0, byte_valid_out = 0.
  - busy_out = 0, done_out = 0, overflow_out = 0, word_count_out = 0.
  - Internal start_q = 0.
- Start detection: start_q registers start_in; start = start_in & ~start_q. A rising edge is only accepted in IDLE; edges in any other state are ignored. A held level never retriggers.
- States: IDLE, RD_ISSUE, RD_WAIT, CHECK, SEND, DONE.
- IDLE:
  - On start: word_count ← 0, overflow ← 0, word pointer ← 0, go RD_ISSUE.
- RD_ISSUE:
  - mem_addr_out = OUT_BASE_ADDR + word pointer. The address is registered and held stable until the next RD_ISSUE.
  - Latency counter ← READ_LATENCY-1, go RD_WAIT.
- RD_WAIT:
  - Count down; at 0 capture mem_data_in into a 32-bit shift register and go CHECK.
  - Data is therefore sampled exactly READ_LATENCY+1 cycles after RD_ISSUE is entered.
- CHECK, terminator: if the captured word == 32'hDEADBEEF, go DONE. This applies even when word_count is 0, giving an empty run with no bytes emitted.
- CHECK, cap: else if word_count == MAX_WORDS, set overflow_out and go DONE. The captured word is not sent.
- CHECK, normal: else byte index ← 0, go SEND.
- SEND:
  - byte_valid_out = 1; byte_out = shift register [31:24].
  - A transfer occurs on byte_valid_out & byte_ready_in. On transfer: shift left 8, byte index +1.
  - On the 4th transfer: byte_valid_out ← 0, word_count +1, word pointer +1, go RD_ISSUE.
  - While valid & ~ready, byte_out and byte_valid_out hold unchanged.
  - byte_valid_out never drops without a transfer, except on reset.
- DONE: done_out = 1 for exactly this one cycle, then go IDLE. busy_out is high in every state except IDLE.
- Byte order per dword: [31:24], [23:16], [15:8], [7:0]. Across dwords: ascending address, which matches the wrapper's dword_1..4 order of the 128-bit block.
- Address arithmetic: 10-bit wrap is permitted but unreachable for OUT_BASE_ADDR=257, MAX_WORDS=255 (max address 512).
- Throughput: with ready held high, each dword costs READ_LATENCY+2 overhead cycles plus 4 byte cycles.
- Reset mid-operation: immediate return to reset state. A partially sent dword is abandoned and byte_valid_out drops in the cycle after reset is sampled.
- start_in falling mid-run: no effect; the run completes.

Decomposition:
- Shared package aes_pkg:
  - AES_OUTPUT_BASE_ADDR = 257
  - AES_TERMINATOR = 32'hDEADBEEF
  - streamer state enum
- The AES wrapper should adopt the same package constants.
- No sub-module. Edge detect, latency counter and 4-byte serializer stay inline; the expected implementation is ~150 lines.

Test Plan:
- Normal run: BRAM[257..261] = 0x3925841D, 0x02DC09FB, 0xDC118597, 0x196A0B32, 0xDEADBEEF; ready=1; pulse start.
  - Expect 16 bytes 39 25 84 1D 02 DC 09 FB DC 11 85 97 19 6A 0B 32.
  - Then a one-cycle done_out pulse, word_count_out = 4, overflow_out = 0.
- Empty run: BRAM[257] = 0xDEADBEEF; start.
  - Expect no byte_valid_out assertion and done_out 4 cycles after start is registered.
  - word_count_out = 0.
- Backpressure: same data as the normal run; ready toggles randomly with a 3-cycle low stretch in mid-dword.
  - byte_out stays stable while valid & ~ready.
  - Byte sequence is identical to the normal run; no duplicates or drops.
- Cap: MAX_WORDS = 2, no terminator in BRAM[257..260].
  - Exactly 8 bytes streamed, then done_out.
  - overflow_out = 1, word_count_out = 2.
- Start handling: hold start_in high for 100 cycles after the first run completes → no second run.
  - Drop then re-raise start_in → a second run starts with overflow cleared.
  - A start edge while busy is ignored.
- Reset mid-SEND: assert rst_in after the 6th byte transfers.
  - Next cycle: byte_valid_out = 0, busy_out = 0, mem_addr_out = 257.
  - A new start replays from byte 0x39.
